// File: rtl/aes_dec_key_sched.sv
// AES-128 decryption round-key source: forward expansion into an 11-entry store, then issue 10..0.
// Optional AES_KEY_ZEROIZE_EN adds a ZERO state that wipes the store after the last key is taken.
module aes_dec_key_sched #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_idx,
    output logic             rk_last
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_ISSUE
`ifdef AES_KEY_ZEROIZE_EN
        , S_ZERO
`endif
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed rather than tabled: inverse as a^254 (0 maps to 0), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq, inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [KEY_W-1:0] next_key(input logic [KEY_W-1:0] k, input logic [3:0] n);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rcon(n), 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t           state;
    logic [KEY_W-1:0] store [0:NR];
    logic [3:0]       exp_cnt;
    logic [KEY_W-1:0] exp_key;

    always_comb exp_key = next_key(store[exp_cnt - 4'd1], exp_cnt);

    // rk_idx doubles as the read pointer; rk_out is prefetched from the store on each handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            rk_out   <= '0;
            rk_idx   <= '0;
            exp_cnt  <= '0;
            for (int i = 0; i <= NR; i++) store[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        store[0] <= key_in;
                        exp_cnt  <= 4'd1;
                        busy     <= 1'b1;
                        state    <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    store[exp_cnt] <= exp_key;
                    exp_cnt        <= exp_cnt + 4'd1;
                    if (exp_cnt == LAST) begin
                        state    <= S_ISSUE;
                        rk_valid <= 1'b1;
                        rk_idx   <= LAST;
                        rk_out   <= exp_key;
                        rk_last  <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (rk_ready) begin
                        if (rk_idx == 4'd0) begin
                            rk_valid <= 1'b0;
                            rk_last  <= 1'b0;
                            rk_out   <= '0;
`ifdef AES_KEY_ZEROIZE_EN
                            state    <= S_ZERO;
`else
                            state    <= S_IDLE;
                            busy     <= 1'b0;
`endif
                        end else begin
                            rk_idx  <= rk_idx - 4'd1;
                            rk_out  <= store[rk_idx - 4'd1];
                            rk_last <= (rk_idx == 4'd1);
                        end
                    end
                end
`ifdef AES_KEY_ZEROIZE_EN
                S_ZERO: begin
                    for (int i = 0; i <= NR; i++) store[i] <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Bench for aes_dec_key_sched: word-array FIPS-197 key-expansion model, directed + randomized steps.
module tb_aes_dec_key_sched;

    logic         clk = 1'b0;
    logic         rst_n, start, rk_ready;
    logic [127:0] key_in;
    logic         busy, rk_valid, rk_last;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;

    aes_dec_key_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out), .rk_idx(rk_idx),
        .rk_last(rk_last)
    );

    always #5 clk = ~clk;

`ifdef AES_KEY_ZEROIZE_EN
    localparam int TAIL = 1;
`else
    localparam int TAIL = 0;
`endif

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sbox_m [0:255];
    logic [127:0] mrk [0:10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Classic generator walk: p steps through GF(2^8)* by x3, q tracks its inverse.
    task automatic build_sbox();
        logic [7:0] p, q, t, x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            t = p[7] ? 8'h1b : 8'h00;
            p = p ^ (p << 1) ^ t;
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_m[p] = x ^ 8'h63;
        end
        sbox_m[0] = 8'h63;
    endtask

    task automatic model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]], sbox_m[temp[15:8]], sbox_m[temp[7:0]]};
                temp = temp ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r <= 10; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic start_key(input logic [127:0] k);
        model(k);
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("busy_after_start", 128'(busy), 128'd1);
    endtask

    task automatic wait_valid(input bit inject, input logic [127:0] other);
        int lat = 0;
        do begin
            tick();
            lat++;
            if (inject && lat == 3) begin
                start  = 1'b1;
                key_in = other;
            end else begin
                start = 1'b0;
            end
        end while (!rk_valid && lat < 40);
        start = 1'b0;
        chk("latency", 128'(lat), 128'd10);
    endtask

    // mode 0: always ready, 1: 1,0,0,1 pattern, 2: random. Returns beat-cycle count.
    task automatic drain(input int mode, input bit inject, input logic [127:0] other, output int cyc);
        int  exp_idx = 10;
        bit  r;
        int  z;
        cyc = 0;
        while (exp_idx >= 0 && cyc < 200) begin
            chk("rk_valid", 128'(rk_valid), 128'd1);
            chk("rk_idx", 128'(rk_idx), 128'(exp_idx));
            chk("rk_out", rk_out, mrk[exp_idx]);
            chk("rk_last", 128'(rk_last), 128'(exp_idx == 0));
            chk("busy_issue", 128'(busy), 128'd1);
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            rk_ready = r;
            if (inject && cyc == 2) begin
                start  = 1'b1;
                key_in = other;
            end
            tick();
            start = 1'b0;
            cyc++;
            if (r) exp_idx--;
        end
        rk_ready = 1'b0;
        chk("drain_done", 128'(exp_idx), 128'(-1));
        chk("valid_after_last", 128'(rk_valid), 128'd0);
        chk("idx_after_last", 128'(rk_idx), 128'd0);
        z = 0;
        while (busy && z < 5) begin
            tick();
            z++;
        end
        chk("busy_tail", 128'(z), 128'(TAIL));
    endtask

    initial begin
        logic [127:0] ka, kb;
        int           n;
        build_sbox();
        rst_n = 1'b0; start = 1'b0; key_in = '0; rk_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_last", 128'(rk_last), 128'd0);
        chk("rst_idx", 128'(rk_idx), 128'd0);
        chk("rst_out", rk_out, 128'd0);
        rst_n = 1'b1;
        tick();

        // FIPS-197 vector, full throughput
        start_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_valid(1'b0, '0);
        chk("fips_idx10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("fips_model1", mrk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        drain(0, 1'b0, '0, n);
        chk("fips_beats", 128'(n), 128'd11);

        // backpressure pattern
        ka = {$urandom, $urandom, $urandom, $urandom};
        start_key(ka);
        wait_valid(1'b0, '0);
        drain(1, 1'b0, '0, n);

        // start pulses during EXPAND and ISSUE are ignored
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = ~ka;
        start_key(ka);
        wait_valid(1'b1, kb);
        drain(2, 1'b1, kb, n);
        tick();
        chk("idle_after_ignored", 128'(busy), 128'd0);

        // reset mid-ISSUE at idx 5
        ka = {$urandom, $urandom, $urandom, $urandom};
        start_key(ka);
        wait_valid(1'b0, '0);
        rk_ready = 1'b1;
        n = 0;
        while (rk_idx != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        chk("reached_idx5", 128'(rk_idx), 128'd5);
        rst_n = 1'b0;
        rk_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_valid", 128'(rk_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_idx", 128'(rk_idx), 128'd0);
        tick();
        chk("no_issue_after_rst", 128'(rk_valid), 128'd0);
        start_key('0);
        wait_valid(1'b0, '0);
        chk("zero_key_idx10", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        drain(0, 1'b0, '0, n);

        // back-to-back: start on the first cycle busy is low
        ka = {$urandom, $urandom, $urandom, $urandom};
        start_key(ka);
        wait_valid(1'b0, '0);
        drain(2, 1'b0, '0, n);
        ka = {$urandom, $urandom, $urandom, $urandom};
        start_key(ka);
        wait_valid(1'b0, '0);
        drain(0, 1'b0, '0, n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
